// File: rtl/branch_history_predictor_pkg.sv
// Shared types for the gshare branch direction predictor.
// Counter encodings, FSM states and default geometry.
package bp_pkg;

    typedef logic [1:0] bp_counter_t;

    localparam bp_counter_t CNT_SNT = 2'b00;
    localparam bp_counter_t CNT_WNT = 2'b01;
    localparam bp_counter_t CNT_WT  = 2'b10;
    localparam bp_counter_t CNT_ST  = 2'b11;

    localparam int BP_DEF_PHT_IDX_WIDTH = 6;
    localparam int BP_DEF_GHR_WIDTH     = 6;

    typedef enum logic {
        BP_INIT  = 1'b0,
        BP_READY = 1'b1
    } bp_state_t;

endpackage

// File: rtl/branch_history_predictor_if.sv
// Fetch/execute-facing bundle of the branch predictor.
// master = pipeline side, slave = predictor.
interface bp_if #(
    parameter int PHT_IDX_WIDTH = 6,
    parameter int GHR_WIDTH     = 6
);
    logic                     lookup_req;
    logic [31:0]              lookup_pc;
    logic                     lookup_ready;
    logic                     pred_valid;
    logic                     pred_taken;
    logic [PHT_IDX_WIDTH-1:0] pred_idx;
    logic                     update_valid;
    logic [PHT_IDX_WIDTH-1:0] update_idx;
    logic                     update_result;
    logic [GHR_WIDTH-1:0]     ghr;

    modport master (
        output lookup_req, lookup_pc, update_valid, update_idx, update_result,
        input  lookup_ready, pred_valid, pred_taken, pred_idx, ghr
    );

    modport slave (
        input  lookup_req, lookup_pc, update_valid, update_idx, update_result,
        output lookup_ready, pred_valid, pred_taken, pred_idx, ghr
    );
endinterface

// File: rtl/branch_history_predictor_branch_counter.sv
// Two-bit saturating counter next-state logic used on the PHT update path.
module branch_counter
    import bp_pkg::*;
(
    input  logic        taken_i,
    input  bp_counter_t cnt_i,
    output bp_counter_t cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        case (cnt_i)
            CNT_SNT: cnt_o = taken_i ? CNT_WNT : CNT_SNT;
            CNT_WNT: cnt_o = taken_i ? CNT_WT  : CNT_SNT;
            CNT_WT:  cnt_o = taken_i ? CNT_ST  : CNT_WNT;
            CNT_ST:  cnt_o = taken_i ? CNT_ST  : CNT_WT;
            default: cnt_o = cnt_i;
        endcase
    end

endmodule

// File: rtl/branch_history_predictor.sv
// Gshare direction predictor: flop-based PHT of 2-bit counters indexed by PC ^ GHR,
// registered 1-cycle lookup, execute-side updates, and a post-reset init walk.
module branch_history_predictor
    import bp_pkg::*;
#(
    parameter int          PHT_IDX_WIDTH = BP_DEF_PHT_IDX_WIDTH,
    parameter int          GHR_WIDTH     = BP_DEF_GHR_WIDTH,
    parameter bp_counter_t INIT_STATE    = CNT_WNT
) (
    input  logic clk,
    input  logic rst,
    bp_if.slave  bus
);

    localparam int PHT_ENTRIES = 1 << PHT_IDX_WIDTH;

    typedef logic [PHT_IDX_WIDTH-1:0] idx_t;
    typedef logic [GHR_WIDTH-1:0]     ghr_t;

    localparam idx_t PHT_LAST = '1;

    bp_state_t   state_q, state_d;
    idx_t        init_ptr_q, init_ptr_d;
    ghr_t        ghr_q, ghr_d;
    logic        pred_valid_q, pred_valid_d;
    logic        pred_taken_q, pred_taken_d;
    idx_t        pred_idx_q, pred_idx_d;
    bp_counter_t pht_q [PHT_ENTRIES];

    logic        ready;
    logic        upd_fire;
    logic        lkp_fire;
    idx_t        lkp_idx;
    bp_counter_t upd_cur;
    bp_counter_t upd_next;
    bp_counter_t lkp_cnt;
    logic        pht_we;
    idx_t        pht_waddr;
    bp_counter_t pht_wdata;

    // PC bits outside the index field do not participate in the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lookup_pc[31:PHT_IDX_WIDTH+2], bus.lookup_pc[1:0]};

    assign upd_cur = pht_q[bus.update_idx];

    branch_counter u_counter (
        .taken_i (bus.update_result),
        .cnt_i   (upd_cur),
        .cnt_o   (upd_next)
    );

    always_comb begin
        ready    = (state_q == BP_READY);
        upd_fire = ready && bus.update_valid;
        lkp_fire = ready && bus.lookup_req;
        lkp_idx  = bus.lookup_pc[PHT_IDX_WIDTH+1:2] ^ idx_t'(ghr_q);

        // Write-first: a same-cycle update to the looked-up entry is visible.
        if (upd_fire && (bus.update_idx == lkp_idx)) begin
            lkp_cnt = upd_next;
        end else begin
            lkp_cnt = pht_q[lkp_idx];
        end

        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        ghr_d        = ghr_q;
        pht_we       = 1'b0;
        pht_waddr    = bus.update_idx;
        pht_wdata    = upd_next;

        case (state_q)
            BP_INIT: begin
                pht_we     = 1'b1;
                pht_waddr  = init_ptr_q;
                pht_wdata  = INIT_STATE;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == PHT_LAST) begin
                    state_d = BP_READY;
                end
            end
            BP_READY: begin
                if (upd_fire) begin
                    pht_we = 1'b1;
                    ghr_d  = {ghr_q[GHR_WIDTH-2:0], bus.update_result};
                end
            end
            default: state_d = BP_INIT;
        endcase

        pred_valid_d = lkp_fire;
        pred_taken_d = lkp_fire ? lkp_cnt[1] : pred_taken_q;
        pred_idx_d   = lkp_fire ? lkp_idx    : pred_idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BP_INIT;
            init_ptr_q   <= '0;
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_idx_q   <= pred_idx_d;
        end
    end

    // The array has no reset of its own; the init walk defines every entry.
    always_ff @(posedge clk) begin
        if (!rst && pht_we) begin
            pht_q[pht_waddr] <= pht_wdata;
        end
    end

    assign bus.lookup_ready = ready;
    assign bus.pred_valid   = pred_valid_q;
    assign bus.pred_taken   = pred_taken_q;
    assign bus.pred_idx     = pred_idx_q;
    assign bus.ghr          = ghr_q;

endmodule

// File: doc/branch_history_predictor.md
Name: branch_history_predictor

Overview:
- Gshare-style direction predictor built around an array of 2-bit saturating counters (pattern history table, PHT).
- Indexes the PHT with fetch PC XOR a global history register (GHR).
- Returns a registered taken/not-taken prediction one cycle after a fetch lookup, and applies resolved-branch updates from execute.
- Owns PHT initialisation after reset through a sequential init walk.

Parameters:
- PHT_IDX_WIDTH, 6, log2 of PHT entries (64 entries).
- GHR_WIDTH, 6, global history bits; must be <= PHT_IDX_WIDTH.
- INIT_STATE, 2'b01, counter value written to every entry during init (weakly not-taken).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- lookup_req  in  1  fetch requests a prediction this cycle
- lookup_pc  in  32  fetch PC
- lookup_ready  out  1  predictor accepts lookups (READY state)
- pred_valid  out  1  prediction outputs valid this cycle
- pred_taken  out  1  predicted direction (counter MSB)
- pred_idx  out  PHT_IDX_WIDTH  PHT index used; carried down the pipe and returned on update_idx
- update_valid  in  1  resolved branch update this cycle
- update_idx  in  PHT_IDX_WIDTH  index from the original pred_idx
- update_result  in  1  actual outcome, 1 = taken
- ghr  out  GHR_WIDTH  current global history (debug/perf)

Behaviour:
- Reset values (cycle after rst=1):
  - state=INIT, init_ptr=0, GHR=0.
  - lookup_ready=0, pred_valid=0, pred_taken=0, pred_idx=0.
- FSM INIT:
  - Each cycle writes INIT_STATE to PHT[init_ptr], then init_ptr++.
  - After writing entry 2^PHT_IDX_WIDTH-1, go to READY.
  - Init takes exactly 64 cycles (default); lookup_ready=1 from the 65th cycle after rst deasserts.
- FSM READY: terminal until rst.
- Index computation: idx = lookup_pc[PHT_IDX_WIDTH+1:2] XOR zero-extended GHR, using the GHR value before any same-cycle update.
- Lookup:
  - If lookup_req && lookup_ready at edge N, then at N+1: pred_valid=1, pred_taken=PHT[idx][1], pred_idx=idx.
  - Latency is 1 cycle; a new lookup is accepted every cycle.
  - Without an accepted lookup, pred_valid=0 and pred_taken/pred_idx hold their last values.
  - lookup_req during INIT is ignored; no pred_valid is produced.
- Update (READY only):
  - On update_valid, PHT[update_idx] takes the saturating next-state value:
    - 00: taken->01, not->00
    - 01: taken->10, not->00
    - 10: taken->11, not->01
    - 11: taken->11, not->10
  - GHR <= {GHR[GHR_WIDTH-2:0], update_result}; the MSB is dropped (shift wrap).
  - update_valid during INIT is dropped: no PHT or GHR change.
- Simultaneous lookup and update, same cycle:
  - If lookup idx == update_idx, the prediction uses the post-update counter (write-first bypass).
  - Lookup idx still uses the pre-shift GHR.
- Back-to-back updates to the same index in consecutive cycles each apply to the value left by the previous one; there are no lost updates.
- rst mid-operation:
  - Any in-flight prediction is discarded: pred_valid=0 next cycle.
  - Init restarts from entry 0 and the GHR clears.
  - All entries read INIT_STATE after init completes.
- No X on outputs after reset.
- PHT is flop-based (no SRAM); reads are combinational from the array, registered at the outputs.

Decomposition:
- Shared package bp_pkg:
  - typedef bp_counter_t (logic [1:0]).
  - Constants CNT_SNT=2'b00, CNT_WNT=2'b01, CNT_WT=2'b10, CNT_ST=2'b11.
  - Enum bp_state_t {BP_INIT, BP_READY}.
- Sub-module: branch_counter, the existing combinational saturating next-state block, instantiated once on the update path.
  - Inputs: update_result and PHT[update_idx].
  - Output: the counter written back, also used as the bypass value.

Test Plan:
- Init: rst=1 for one cycle, then low → lookup_ready=0 for 64 cycles, 1 on cycle 65; lookup pc=0x0 → next cycle pred_valid=1, pred_taken=0, pred_idx=0.
- Saturate up: after init, three updates idx=5, result=1 → counter 10, 11, 11; GHR=6'b000111; lookup pc=0x08 (bits 000010 ^ 000111 = 5) → pred_taken=1, pred_idx=5.
- Saturate down: continue with three updates idx=5, result=0 → counter 10, 01, 00; GHR=6'b111000; lookup pc=0xF4 (111101 ^ 111000 = 5) → pred_taken=0, pred_idx=5.
- Bypass: GHR=0, entry 9=01; same cycle update_idx=9, result=1 and lookup pc=0x24 → next cycle pred_taken=1, pred_idx=9; GHR=000001 afterward.
- Update during init: update_valid=1, idx=3, result=1 at init cycle 10 → after READY, GHR=0 and lookup pc=0x0C gives pred_taken=0.
- Reset mid-op: set entry 9 to 11, issue a lookup, assert rst on the following edge → pred_valid=0, lookup_ready=0 for 64 cycles; lookup pc=0x24 then gives pred_taken=0.
